// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared encodings and bit positions for the interrupt controller
package interrupt_controller_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_REQ     = 2'd1;
   localparam state_t ST_SERVICE = 2'd2;

   localparam int IDN_W        = 8;
   localparam int GIE_BIT      = 31;
   localparam int STAT_REQ_BIT = 30;
   localparam int STAT_SVC_BIT = 31;
   localparam int STAT_IDN_LSB = 8;
   localparam int STAT_IDN_MSB = 15;

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - register bus between CPU and interrupt controller
interface interrupt_controller_if #(
   parameter int BITS = 32
);
   logic            we;
   logic            re;
   logic [BITS-1:0] memAddr;
   logic [BITS-1:0] dataBusIn;
   logic [BITS-1:0] dataBusOut;

   modport master (output we, re, memAddr, dataBusIn, input dataBusOut);
   modport slave  (input we, re, memAddr, dataBusIn, output dataBusOut);
endinterface

// File: rtl/interrupt_controller_priority_encoder.sv
// rtl/interrupt_controller_priority_encoder.sv - lowest-set-index priority encoder
module interrupt_controller_priority_encoder
   import interrupt_controller_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   output logic [IDN_W-1:0] idx,
   output logic             valid
);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDN_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised interrupt controller with STATUS/CTRL registers
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int              BITS      = 32,
   parameter int              NUM_SRC   = 4,
   parameter logic [BITS-1:0] BASE      = 32'hF0000100,
   parameter logic [BITS-1:0] CTRL_BASE = 32'hF0000104
) (
   input  logic                clk,
   input  logic                reset,
   interrupt_controller_if.slave bus,
   input  logic [NUM_SRC-1:0]  irq_in,
   input  logic                int_ack,
   input  logic                int_ret,
   output logic                int_req,
   output logic [IDN_W-1:0]    int_idn
);

   state_t               state;
   logic [NUM_SRC-1:0]   mask;
   logic                 gie;
   logic [NUM_SRC-1:0]   qualified;
   logic [IDN_W-1:0]     winIdx;
   logic                 winValid;
   logic                 ctrlHit;
   logic                 statHit;
   logic                 ctrlWrite;
   logic [BITS-1:0]      ctrlReg;
   logic [BITS-1:0]      statReg;
   logic                 unusedData;

   assign qualified = irq_in & mask;
   assign ctrlHit   = (bus.memAddr == CTRL_BASE);
   assign statHit   = (bus.memAddr == BASE);
   assign ctrlWrite = bus.we && ctrlHit;
   assign unusedData = ^bus.dataBusIn;

   interrupt_controller_priority_encoder #(.N(NUM_SRC)) u_prio (
      .req   (qualified),
      .idx   (winIdx),
      .valid (winValid)
   );

   // FSM transitions are placed after the bus write so their GIE update wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         mask    <= '0;
         gie     <= 1'b0;
         int_idn <= '0;
         int_req <= 1'b0;
      end else begin
         if (ctrlWrite) begin
            mask <= bus.dataBusIn[NUM_SRC-1:0];
            gie  <= bus.dataBusIn[GIE_BIT];
         end
         case (state)
            ST_IDLE: begin
               if (gie && winValid) begin
                  state   <= ST_REQ;
                  int_idn <= winIdx;
                  int_req <= 1'b1;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state   <= ST_SERVICE;
                  gie     <= 1'b0;
                  int_req <= 1'b0;
               end
            end
            ST_SERVICE: begin
               if (int_ret) begin
                  state <= ST_IDLE;
                  gie   <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      ctrlReg                  = '0;
      ctrlReg[NUM_SRC-1:0]     = mask;
      ctrlReg[GIE_BIT]         = gie;
      statReg                  = '0;
      statReg[NUM_SRC-1:0]     = qualified;
      statReg[STAT_IDN_MSB:STAT_IDN_LSB] = int_idn;
      statReg[STAT_REQ_BIT]    = (state == ST_REQ);
      statReg[STAT_SVC_BIT]    = (state == ST_SERVICE);
   end

   always_comb begin
      bus.dataBusOut = '0;
      if (bus.re && !bus.we) begin
         if (statHit)
            bus.dataBusOut = statReg;
         else if (ctrlHit)
            bus.dataBusOut = ctrlReg;
      end
   end

endmodule
